// File: rtl/ethrxfilt_if.sv
// Receive buffer write stream and frame-ready handshake
// seen by the destination-address filter.
interface ethrxfilt_if;
  logic [8:0]  rxaddr;
  logic [31:0] rxdbus;
  logic        rxwrn;
  logic        rxrdy_i;
  logic        rxdone_o;
  logic        rxrdy_o;
  logic        rxdone_i;

  modport master (
    output rxaddr, rxdbus, rxwrn,
    output rxrdy_i, rxdone_i,
    input  rxdone_o, rxrdy_o
  );

  modport slave (
    input  rxaddr, rxdbus, rxwrn,
    input  rxrdy_i, rxdone_i,
    output rxdone_o, rxrdy_o
  );
endinterface

// File: rtl/ethrxfilt.sv
// DELQA receive destination-address filter: captures the DA
// from buffer writes and forwards or silently drops the frame.
module ethrxfilt #(
  parameter int NENT = 14,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  ethrxfilt_if.slave      rx,
  input  logic            mcast,
  input  logic            promis,
  input  logic            tbl_we,
  input  logic [3:0]      tbl_idx,
  input  logic [47:0]     tbl_dat,
  input  logic            tbl_clr,
  output logic [CNTW-1:0] rejcnt,
  output logic            accept
);

  localparam logic [3:0] LAST = 4'(NENT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP1,
    S_CMP,
    S_WAIT,
    S_FWD,
    S_DROP
  } state_t;

  state_t            r_st;
  logic [47:0]       r_tbl [NENT];
  logic [NENT-1:0]   r_vld;
  logic [47:0]       r_dmac;
  logic [3:0]        r_idx;
  logic              r_match;
  logic              r_rxrdy_o;
  logic              r_rxdone_o;
  logic [CNTW-1:0]   r_rejcnt;
  logic              r_accept;

  logic              w_idx_ok;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_hit;
  logic              w_fast;
  logic              w_last;
  logic [CNTW-1:0]   w_rejinc;

  assign w_idx_ok = tbl_idx < 4'(NENT);
  assign w_wr0    = !rx.rxwrn && (rx.rxaddr == 9'd0);
  assign w_wr1    = !rx.rxwrn && (rx.rxaddr == 9'd1);
  assign w_hit    = r_vld[r_idx] && (r_tbl[r_idx] == r_dmac);
  assign w_fast   = promis || (&r_dmac) || (r_dmac[0] && mcast);
  assign w_last   = r_idx == LAST;
  assign w_rejinc = (&r_rejcnt) ? r_rejcnt : r_rejcnt + CNTW'(1);

  always_ff @(posedge clk) begin
    if (tbl_we && w_idx_ok)
      r_tbl[tbl_idx] <= tbl_dat;
  end

  // clear first so a same-cycle write still leaves its entry valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      if (tbl_clr)
        r_vld <= '0;
      if (tbl_we && w_idx_ok)
        r_vld[tbl_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st       <= S_IDLE;
      r_dmac     <= '0;
      r_idx      <= '0;
      r_match    <= 1'b0;
      r_rxrdy_o  <= 1'b0;
      r_rxdone_o <= 1'b0;
      r_rejcnt   <= '0;
      r_accept   <= 1'b0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (rx.rxrdy_i) begin
            r_st       <= S_DROP;
            r_rxdone_o <= 1'b1;
            r_accept   <= 1'b0;
            r_rejcnt   <= w_rejinc;
          end else if (w_wr0) begin
            r_dmac[31:0] <= rx.rxdbus;
            r_st         <= S_CAP1;
          end
        end
        S_CAP1: begin
          if (rx.rxrdy_i) begin
            r_st       <= S_DROP;
            r_rxdone_o <= 1'b1;
            r_accept   <= 1'b0;
            r_rejcnt   <= w_rejinc;
          end else if (w_wr1) begin
            r_dmac[47:32] <= rx.rxdbus[15:0];
            r_idx         <= '0;
            r_match       <= 1'b0;
            r_st          <= S_CMP;
          end else if (w_wr0) begin
            r_dmac[31:0] <= rx.rxdbus;
          end
        end
        S_CMP: begin
          if (w_wr0) begin
            r_dmac[31:0] <= rx.rxdbus;
            r_st         <= S_CAP1;
          end else if (w_hit || (w_fast && r_idx == '0)) begin
            r_match <= 1'b1;
            r_st    <= S_WAIT;
          end else if (w_last) begin
            r_st <= S_WAIT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_WAIT: begin
          if (rx.rxrdy_i) begin
            if (r_match) begin
              r_st       <= S_FWD;
              r_rxrdy_o  <= 1'b1;
              r_rxdone_o <= rx.rxdone_i;
              r_accept   <= 1'b1;
            end else begin
              r_st       <= S_DROP;
              r_rxdone_o <= 1'b1;
              r_accept   <= 1'b0;
              r_rejcnt   <= w_rejinc;
            end
          end else if (w_wr0) begin
            r_dmac[31:0] <= rx.rxdbus;
            r_st         <= S_CAP1;
          end
        end
        S_FWD: begin
          r_rxrdy_o  <= rx.rxrdy_i;
          r_rxdone_o <= rx.rxdone_i;
          if (!rx.rxrdy_i && !rx.rxdone_i)
            r_st <= S_IDLE;
        end
        S_DROP: begin
          r_rxrdy_o <= 1'b0;
          if (!rx.rxrdy_i) begin
            r_rxdone_o <= 1'b0;
            r_st       <= S_IDLE;
          end else begin
            r_rxdone_o <= 1'b1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign rx.rxrdy_o  = r_rxrdy_o;
  assign rx.rxdone_o = r_rxdone_o;
  assign rejcnt      = r_rejcnt;
  assign accept      = r_accept;

endmodule

// File: tb/tb_ethrxfilt.sv
// Randomised scoreboard bench for ethrxfilt with a frame-level
// acceptance model; a narrow counter makes saturation reachable.
module tb_ethrxfilt;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ethrxfilt_if rx ();
  logic          mcast = 1'b0;
  logic          promis = 1'b0;
  logic          tbl_we = 1'b0;
  logic          tbl_clr = 1'b0;
  logic [3:0]    tbl_idx = '0;
  logic [47:0]   tbl_dat = '0;
  logic [CW-1:0] rejcnt;
  logic          accept;

  ethrxfilt #(.NENT(14), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .mcast(mcast), .promis(promis),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_dat(tbl_dat), .tbl_clr(tbl_clr),
    .rejcnt(rejcnt), .accept(accept)
  );

  typedef struct { bit acc; int rej; } exp_t;
  exp_t        sb[$];
  logic [47:0] m_tbl [14];
  bit          m_vld [14];
  int          m_rej = 0;
  int          total = 0;
  int          bad = 0;
  bit          inf = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] mac(input logic [47:0] be);
    logic [47:0] o;
    for (int i = 0; i < 6; i++) o[8*i +: 8] = be[8*(5-i) +: 8];
    return o;
  endfunction

  function automatic bit m_accept(input logic [47:0] da);
    if (promis || (&da) || (da[0] && mcast)) return 1'b1;
    for (int i = 0; i < 14; i++)
      if (m_vld[i] && m_tbl[i] == da) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tw(input bit we, input int idx,
                    input logic [47:0] d, input bit clr);
    tick();
    tbl_we = we; tbl_idx = idx[3:0]; tbl_dat = d; tbl_clr = clr;
    if (clr) for (int i = 0; i < 14; i++) m_vld[i] = 1'b0;
    if (we && idx < 14) begin
      m_tbl[idx] = d;
      m_vld[idx] = 1'b1;
    end
    tick();
    tbl_we = 1'b0; tbl_clr = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    tick();
    rx.rxwrn = 1'b0; rx.rxaddr = a[8:0]; rx.rxdbus = d;
  endtask

  task automatic push_exp(input bit acc);
    if (!acc && m_rej < MAXC) m_rej++;
    sb.push_back('{acc, m_rej});
  endtask

  task automatic wait_dec(output int lat);
    lat = 0;
    do begin tick(); lat++; end
    while (!(rx.rxrdy_o || rx.rxdone_o) && lat < 100);
    if (lat >= 100) begin
      $display("FAIL decision_timeout t=%0t", $time);
      $fatal(1, "no decision");
    end
  endtask

  task automatic frame(input logic [47:0] da, input logic [47:0] da2,
                       input bit rs, input bit runt, input int early);
    logic [47:0] eda;
    bit acc;
    int lat;
    wr(0, da[31:0]);
    if (!runt) begin
      wr(1, {16'h0, da[47:32]});
      if (rs) begin
        wr(0, da2[31:0]);
        wr(1, {16'h0, da2[47:32]});
      end
    end
    eda = rs ? da2 : da;
    acc = runt ? 1'b0 : m_accept(eda);
    if (!runt && early == 0)
      for (int a = 2; a < 16; a++) wr(a, $urandom);
    tick();
    rx.rxwrn = 1'b1; rx.rxrdy_i = 1'b1;
    push_exp(acc);
    wait_dec(lat);
    chk("latency", lat, (early != 0) ? early : 1);
    if (rx.rxrdy_o) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("fwd_rdy_hold", rx.rxrdy_o, 1);
        chk("fwd_done_low", rx.rxdone_o, 0);
      end
      rx.rxdone_i = 1'b1; tick();
      chk("fwd_done_prop", rx.rxdone_o, 1);
      rx.rxrdy_i = 1'b0; tick();
      chk("fwd_rdy_fall", rx.rxrdy_o, 0);
      rx.rxdone_i = 1'b0; tick();
      chk("fwd_done_fall", rx.rxdone_o, 0);
    end else begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("drop_done_hold", rx.rxdone_o, 1);
        chk("drop_rdy_low", rx.rxrdy_o, 0);
      end
      rx.rxrdy_i = 1'b0; tick();
      chk("drop_done_fall", rx.rxdone_o, 0);
    end
  endtask

  function automatic logic [47:0] rnd_da();
    logic [63:0] r;
    int k;
    r = {$urandom, $urandom};
    k = $urandom % 10;
    if (k < 4) begin
      for (int t = 0; t < 8; t++) begin
        int j;
        j = $urandom % 14;
        if (m_vld[j]) return m_tbl[j];
      end
    end
    if (k == 4) return 48'hFFFF_FFFF_FFFF;
    if (k == 5 || k == 6) return r[47:0] | 48'h1;
    return r[47:0] & ~48'h1;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1; rx.rxrdy_i = 1'b0; rx.rxdone_i = 1'b0; rx.rxwrn = 1'b1;
    m_rej = 0;
    for (int i = 0; i < 14; i++) m_vld[i] = 1'b0;
    tick();
    chk("rst_rxrdy_o", rx.rxrdy_o, 0);
    chk("rst_rxdone_o", rx.rxdone_o, 0);
    chk("rst_rejcnt", rejcnt, 0);
    chk("rst_accept", accept, 0);
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
        inf = 0;
      end else if (!inf && (rx.rxrdy_o || rx.rxdone_o)) begin
        inf = 1;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected rdy=%0b done=%0b t=%0t",
                   rx.rxrdy_o, rx.rxdone_o, $time);
        end else begin
          e = sb.pop_front();
          chk("decision", rx.rxrdy_o, e.acc);
          chk("accept", accept, e.acc);
          chk("rejcnt", rejcnt, e.rej);
        end
      end else if (inf && !rx.rxrdy_o && !rx.rxdone_o) begin
        inf = 0;
      end
    end
  end

  initial begin
    logic [47:0] da1, dno, db;
    int lat;
    rx.rxwrn = 1'b1; rx.rxaddr = '0; rx.rxdbus = '0;
    rx.rxrdy_i = 1'b0; rx.rxdone_i = 1'b0;
    repeat (3) tick();
    reset_pulse();

    da1 = mac(48'h08002B112233);
    dno = mac(48'h08002B999999);
    tw(1, 3, da1, 0);
    frame(da1, 0, 0, 0, 0);
    chk("fwd_accept", accept, 1);
    chk("fwd_rejcnt", rejcnt, 0);
    frame(dno, 0, 0, 0, 0);
    chk("drop_accept", accept, 0);
    chk("drop_rejcnt", rejcnt, 1);

    frame(mac(48'h01005E000001), 0, 0, 0, 0);
    chk("mcast_off", accept, 0);
    mcast = 1'b1;
    frame(mac(48'h01005E000001), 0, 0, 0, 0);
    chk("mcast_on", accept, 1);
    mcast = 1'b0;
    tw(0, 0, 0, 1);
    frame(48'hFFFF_FFFF_FFFF, 0, 0, 0, 0);
    chk("bcast", accept, 1);

    for (int i = 0; i < 14; i++)
      tw(1, i, mac(48'h020000000000 | 48'(i)), 0);
    promis = 1'b1;
    frame(mac(48'h0A0B0C0D0E0F), 0, 0, 0, 2);
    promis = 1'b0;
    frame(mac(48'h0A0B0C0D0E0F), 0, 0, 0, 15);
    frame(48'hFFFF_FFFF_FFFF, 0, 0, 1, 0);

    db = mac(48'h08002BAABBCC);
    tw(1, 13, db, 0);
    frame(dno, db, 1, 0, 0);
    chk("restart_new_da", accept, 1);
    frame(db, dno, 1, 0, 0);
    chk("restart_new_da2", accept, 0);

    frame(db, 0, 0, 0, 0);
    wr(0, dno[31:0]);
    wr(1, {16'h0, dno[47:32]});
    tick();
    rx.rxwrn = 1'b1;
    reset_pulse();
    frame(db, 0, 0, 0, 0);
    chk("tbl_cleared", accept, 0);

    tw(1, 5, da1, 0);
    wr(0, da1[31:0]);
    wr(1, {16'h0, da1[47:32]});
    for (int a = 2; a < 16; a++) wr(a, $urandom);
    tick();
    rx.rxwrn = 1'b1; rx.rxrdy_i = 1'b1;
    push_exp(1'b1);
    wait_dec(lat);
    tick();
    chk("fwd_before_rst", rx.rxrdy_o, 1);
    reset_pulse();
    frame(da1, 0, 0, 0, 0);
    chk("after_rst_fwd", accept, 0);
    tw(1, 5, da1, 0);
    frame(da1, 0, 0, 0, 0);
    chk("after_rst_prog", accept, 1);

    for (int n = 0; n < 200; n++) begin
      bit runt, rs;
      repeat ($urandom % 3)
        tw(($urandom % 4) != 0, $urandom % 16,
           {$urandom, $urandom} & 48'hFFFF_FFFF_FFFE, ($urandom % 10) == 0);
      mcast  = $urandom % 2;
      promis = ($urandom % 8) == 0;
      runt = ($urandom % 10) == 0;
      rs   = !runt && (($urandom % 10) == 0);
      frame(rnd_da(), rnd_da(), rs, runt, 0);
    end

    mcast = 1'b0; promis = 1'b0;
    tw(0, 0, 0, 1);
    for (int n = 0; n < 17; n++) frame(dno, 0, 0, 0, 0);
    chk("rejcnt_sat", rejcnt, MAXC);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
